load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit: formats CPU accesses onto a word-wide memory port
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        lat_store;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;
    logic        timed_out;

    logic        legal;
    logic        aligned;
    logic        req_ok;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] fmt_load;

    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !req_store;
            default:                legal = 1'b0;
        endcase
        aligned = 1'b1;
        if (funct3[1:0] == 2'b01 && addr[0])
            aligned = 1'b0;
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            aligned = 1'b0;
        req_ok = legal && aligned;
    end

    // Loads use the same byte-enable shape as stores so the memory sees the true access width.
    always_comb begin
        fmt_be    = 4'b1111;
        fmt_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                fmt_be    = 4'b0001 << addr[1:0];
                fmt_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                fmt_be    = addr[1] ? 4'b1100 : 4'b0011;
                fmt_wdata = {2{wdata[15:0]}};
            end
            default: begin
                fmt_be    = 4'b1111;
                fmt_wdata = wdata;
            end
        endcase
    end

    always_comb begin
        lane_b   = mem_rdata[{lat_off, 3'b000} +: 8];
        lane_h   = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        fmt_load = mem_rdata;
        case (lat_funct3)
            3'b000:  fmt_load = {{24{lane_b[7]}}, lane_b};
            3'b001:  fmt_load = {{16{lane_h[15]}}, lane_h};
            3'b100:  fmt_load = {24'd0, lane_b};
            3'b101:  fmt_load = {16'd0, lane_h};
            default: fmt_load = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            lat_store  <= 1'b0;
            lat_funct3 <= 3'd0;
            lat_off    <= 2'd0;
            timed_out  <= 1'b0;
            load_data  <= 32'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ok) begin
                        state      <= ACCESS;
                        cnt        <= 8'd0;
                        timed_out  <= 1'b0;
                        lat_store  <= req_store;
                        lat_funct3 <= funct3;
                        lat_off    <= addr[1:0];
                        mem_addr   <= {addr[31:2], 2'b00};
                        mem_wdata  <= fmt_wdata;
                        mem_be     <= fmt_be;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state <= RESP;
                        if (!lat_store)
                            load_data <= fmt_load;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        state     <= RESP;
                        timed_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Input-dependent outputs are gated by reset so they read 0 while reset is held.
    assign stall   = reset && ((state == IDLE && req_valid && req_ok) || state == ACCESS);
    assign err     = reset && ((state == IDLE && req_valid && !req_ok) || (state == RESP && timed_out));
    assign done    = (state == RESP) && !timed_out;
    assign mem_req = (state == ACCESS);
    assign mem_we  = (state == ACCESS) && lat_store;

endmodule
